miriscv_lsu: RTL and testbench

Load/store unit that sequences one data-memory transaction per load or store decoded by the core. Its inputs are the decoder outputs mem_req/mem_we/mem_size, the ALU result used as the address, and RS2 as store data. It drives a request/grant/rvalid data-memory port and stalls the core until the access completes. On loads it returns sign- or zero-extended read data for GPR writeback when WB_LSU_DATA is selected.

---
 rtl/miriscv_lsu.sv | 153 +++++++++++++++
 tb/tb_miriscv_lsu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu.sv
// Load/store unit: one request/grant/rvalid data-memory transaction per decoded load or store.
// It stalls the core until DONE and returns sign- or zero-extended load data.
module miriscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        err_q;
  logic [31:0] cnt;
  logic        req_ok;
  logic        timeout;

  function automatic logic size_legal(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_H) || (size == LDST_W) ||
           (size == LDST_BU) || (size == LDST_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
    logic half;
    half = (size == LDST_H) || (size == LDST_HU);
    return (half && off[0]) || ((size == LDST_W) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: return 4'b0001 << off;
      LDST_H, LDST_HU: return 4'b0011 << off;
      LDST_W:          return 4'b1111;
      default:         return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size)
      LDST_B, LDST_BU: return {4{d[7:0]}};
      LDST_H, LDST_HU: return {2{d[15:0]}};
      default:         return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0] sel;
    sel = rdata >> {off, 3'b000};
    case (size)
      LDST_B:  return {{24{sel[7]}}, sel[7:0]};
      LDST_BU: return {24'd0, sel[7:0]};
      LDST_H:  return {{16{sel[15]}}, sel[15:0]};
      LDST_HU: return {16'd0, sel[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign req_ok  = size_legal(lsu_size_i) && !misaligned(lsu_size_i, lsu_addr_i[1:0]);
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  // Handshake completion takes priority over a timeout in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (lsu_req_i) state_next = req_ok ? REQ : DONE;
      REQ:  if (data_gnt_i) state_next = RESP;
            else if (timeout) state_next = DONE;
      RESP: if (data_rvalid_i || timeout) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      off_q      <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      err_q      <= 1'b0;
      cnt        <= 32'd0;
      lsu_data_o <= 32'd0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= 32'd0;
      else if ((state == REQ) || (state == RESP)) cnt <= cnt + 32'd1;

      case (state)
        IDLE: if (lsu_req_i) begin
          we_q    <= lsu_we_i;
          size_q  <= lsu_size_i;
          off_q   <= lsu_addr_i[1:0];
          addr_q  <= {lsu_addr_i[31:2], 2'b00};
          wdata_q <= calc_wdata(lsu_size_i, lsu_data_i);
          be_q    <= calc_be(lsu_size_i, lsu_addr_i[1:0]);
          err_q   <= !req_ok;
        end
        REQ: if (!data_gnt_i && timeout) err_q <= 1'b1;
        RESP: begin
          if (data_rvalid_i) begin
            if (!we_q) lsu_data_o <= extend_load(size_q, off_q, data_rdata_i);
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        DONE: err_q <= 1'b0;
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign data_req_o      = (state == REQ);
  assign data_we_o       = we_q;
  assign data_be_o       = be_q;
  assign data_addr_o     = addr_q;
  assign data_wdata_o    = wdata_q;
  assign lsu_err_o       = (state == DONE) && err_q;
  assign lsu_stall_req_o = lsu_req_i && (state != DONE);

endmodule

// File: tb/tb_miriscv_lsu.sv
// Bench for miriscv_lsu: directed scenarios plus randomized loads/stores against
// an arithmetic reference of access legality, byte lanes, extension and latency.
module tb_miriscv_lsu;

  localparam int TO = 4;

  logic        clk;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_ld = 32'd0;

  miriscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [2:0] sz, input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    case (sz)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (off % 2) == 0;
      3'd2:       return off == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] sz, input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    case (sz)
      3'd0, 3'd4: return 32'd1 << off;
      3'd1, 3'd5: return 32'd3 << off;
      default:    return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
    case (sz)
      3'd0, 3'd4: return (d & 32'hFF) * 32'h0101_0101;
      3'd1, 3'd5: return (d & 32'hFFFF) * 32'h0001_0001;
      default:    return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] sel, v;
    sel = rd >> (8 * (a % 4));
    case (sz)
      3'd0: begin v = sel & 32'hFF;   return (v >= 32'd128)   ? v - 32'd256   : v; end
      3'd4: return sel & 32'hFF;
      3'd1: begin v = sel & 32'hFFFF; return (v >= 32'd32768) ? v - 32'd65536 : v; end
      3'd5: return sel & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  // gd/rd: number of cycles the memory waits before gnt / rvalid.
  task automatic do_txn(input string tag, input logic we, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] rdata);
    bit legal, to_req, to_resp, gnt_given;
    int exp_req, exp_stall, stall_cnt, req_cnt, resp_k, cyc;
    legal     = m_legal(sz, addr);
    to_req    = legal && (gd >= TO);
    to_resp   = legal && !to_req && (rd >= TO);
    exp_req   = !legal ? 0 : (to_req ? TO : gd + 1);
    exp_stall = 1 + exp_req + ((legal && !to_req) ? (to_resp ? TO : rd + 1) : 0);
    if (legal && !we && !to_req && !to_resp) model_ld = m_load(sz, addr, rdata);

    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz;
    lsu_addr_i = addr; lsu_data_i = wd;
    #1;
    stall_cnt = 0; req_cnt = 0; resp_k = 0; gnt_given = 0; cyc = 0;
    while (lsu_stall_req_o && cyc < 40) begin
      stall_cnt++;
      if (data_req_o) begin
        if (req_cnt == 0) begin
          chk({tag, "_addr"}, data_addr_o, {addr[31:2], 2'b00});
          chk({tag, "_be"}, 32'(data_be_o), m_be(sz, addr));
          chk({tag, "_we"}, 32'(data_we_o), 32'(we));
          if (we) chk({tag, "_wdata"}, data_wdata_o, m_wdata(sz, wd));
        end
        data_gnt_i = (req_cnt == gd);
        if (data_gnt_i) gnt_given = 1;
        req_cnt++;
        data_rvalid_i = 1'($urandom);
        data_rdata_i = $urandom;
      end else if (gnt_given) begin
        data_gnt_i = 1'($urandom);
        data_rvalid_i = (resp_k == rd);
        data_rdata_i = data_rvalid_i ? rdata : $urandom;
        resp_k++;
      end else begin
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'($urandom);
        data_rdata_i = $urandom;
      end
      tick();
      cyc++;
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
    chk({tag, "_err"}, 32'(lsu_err_o), 32'(!legal || to_req || to_resp));
    chk({tag, "_ldata"}, lsu_data_o, model_ld);
    chk({tag, "_done_req"}, 32'(data_req_o), 32'd0);
    lsu_req_i = 1'b0;
    tick();
    chk({tag, "_idle_err"}, 32'(lsu_err_o), 32'd0);
    chk({tag, "_idle_ldata"}, lsu_data_o, model_ld);
  endtask

  initial begin
    logic        we;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [2:0]  ld_sizes [8];
    logic [2:0]  st_sizes [4];
    ld_sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    st_sizes = '{3'd0, 3'd1, 3'd2, 3'd7};

    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
    lsu_addr_i = 32'd0; lsu_data_i = 32'd0; data_gnt_i = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
    tick(); tick();
    chk("rst_req", 32'(data_req_o), 32'd0);
    chk("rst_we", 32'(data_we_o), 32'd0);
    chk("rst_be", 32'(data_be_o), 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    chk("rst_wdata", data_wdata_o, 32'd0);
    chk("rst_err", 32'(lsu_err_o), 32'd0);
    chk("rst_ldata", lsu_data_o, 32'd0);
    rst_i = 1'b0;
    tick();
    chk("stale_rvalid_ldata", lsu_data_o, 32'd0);
    chk("stale_stall", 32'(lsu_stall_req_o), 32'd0);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;

    do_txn("lw",   1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    do_txn("lb",   1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);
    do_txn("lbu",  1'b0, 3'd4, 32'h103, 32'h0, 1, 2, 32'h80FF_1234);
    do_txn("sh",   1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 0, 0, 32'h5555_5555);
    do_txn("lw_mis", 1'b0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h1111_1111);
    do_txn("lh_illegal", 1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 32'h2222_2222);
    do_txn("gnt_timeout", 1'b0, 3'd2, 32'h400, 32'h0, 20, 0, 32'h3333_3333);
    do_txn("rv_timeout",  1'b0, 3'd2, 32'h404, 32'h0, 0, 20, 32'h4444_4444);

    // Reset while waiting for rvalid, then a late rvalid arrives.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h300;
    tick();
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    chk("rstm_resp_req", 32'(data_req_o), 32'd0);
    chk("rstm_resp_stall", 32'(lsu_stall_req_o), 32'd1);
    rst_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    tick();
    chk("rstm_req", 32'(data_req_o), 32'd0);
    chk("rstm_ldata", lsu_data_o, 32'd0);
    chk("rstm_stall", 32'(lsu_stall_req_o), 32'd1);
    rst_i = 1'b0; lsu_req_i = 1'b0;
    tick();
    chk("rstm_late_rvalid", lsu_data_o, 32'd0);
    chk("rstm_idle_stall", 32'(lsu_stall_req_o), 32'd0);
    data_rvalid_i = 1'b0;
    model_ld = 32'd0;

    for (int i = 0; i < 120; i++) begin
      we = 1'($urandom);
      sz = we ? st_sizes[$urandom % 4] : ld_sizes[$urandom % 8];
      addr = $urandom;
      if (($urandom % 3) != 0) begin
        if (sz == 3'd2) addr[1:0] = 2'b00;
        else if (sz == 3'd1 || sz == 3'd5) addr[0] = 1'b0;
      end
      do_txn("rnd", we, sz, addr, $urandom, int'($urandom % 6), int'($urandom % 6), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
